uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receiver (8-bit data plus 1-cycle valid strobe).
- Frames 5-byte command packets: SYNC, ADDR, DATA_HI, DATA_LO, CSUM.
- Validates each packet and issues a single-cycle register write to the camera/filter control register file.
- Sits between the UART receiver and the control register bank.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 9600, line rate, used only to size the inter-byte timeout
TIMEOUT_BYTES, 4, inter-byte gap (in 10-bit character times) that aborts a partial packet
SYNC_BYTE, 8'hAA, packet start marker

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  synchronous reset, active-high
in_data  input  8  received byte; valid only when in_valid=1
in_valid  input  1  1-cycle strobe per received byte
reg_wr_en  output  1  1-cycle write strobe for a validated packet
reg_addr  output  8  register address; held until the next write
reg_wr_data  output  16  write data {DATA_HI, DATA_LO}; held until the next write
err_valid  output  1  1-cycle error strobe
err_code  output  2  error cause: 2'b01 checksum, 2'b10 timeout; held until the next error
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0; address, data and checksum capture registers 0.
- Reset overrides everything, including a byte arriving in the same cycle. A packet in progress is discarded; no write and no error is issued.
- FSM states: IDLE, ADDR, DHI, DLO, CSUM.
  - IDLE: in_valid with in_data==SYNC_BYTE -> ADDR. Any other byte is dropped silently with no error.
  - ADDR: on in_valid, capture address, running xor = byte -> DHI.
  - DHI: on in_valid, capture high byte, xor ^= byte -> DLO.
  - DLO: on in_valid, capture low byte, xor ^= byte -> CSUM.
  - CSUM: on in_valid, compare byte to xor, then -> IDLE.
    - Match: the next cycle reg_wr_en=1, with reg_addr and reg_wr_data updated in the same cycle.
    - Mismatch: the next cycle err_valid=1, err_code=01. reg_* are unchanged.
- No resync inside a packet: a SYNC_BYTE value received in ADDR/DHI/DLO/CSUM is treated as ordinary data.
- Latency: exactly 1 cycle from the checksum byte's in_valid to reg_wr_en or err_valid.
- reg_wr_en and err_valid are never high together.
- Timeout:
  - TIMEOUT_CYC = TIMEOUT_BYTES*10*(CLK_FREQ/UART_BPS). Counter width = $clog2(TIMEOUT_CYC+1).
  - The counter is cleared in IDLE and on every in_valid. Otherwise it increments while busy.
  - When the counter equals TIMEOUT_CYC-1 and in_valid=0: the next cycle the FSM goes to IDLE, err_valid=1, err_code=10, and the counter clears.
  - If in_valid coincides with the terminal count, the byte wins: it is processed normally and no timeout occurs.
- A byte arriving in the same cycle as a reg_wr_en/err_valid strobe is handled normally from IDLE, so back-to-back packets need no gap.
- busy: combinational from state, equal to (state != IDLE).

Decomposition:
- Shared package (uart_pkg) holds:
  - state enum
  - error code constants: ERR_NONE=0, ERR_CSUM=1, ERR_TIMEOUT=2
  - default SYNC_BYTE
  - the BAUD_CNT_MAX formula, shared with the UART receiver and transmitter
- One natural sub-module: uart_gap_timer. It is the loadable timeout counter, with inputs clear/enable and output expire.
- The FSM and capture registers stay in the parent.

Test Plan:
- Nominal packet: bytes AA 10 12 34 36 -> one reg_wr_en pulse 1 cycle after the last strobe, reg_addr=0x10, reg_wr_data=0x1234, no err_valid.
- Bad checksum: AA 10 12 34 37 -> err_valid pulse with err_code=01, no reg_wr_en, reg_* keep their previous values.
- Timeout (CLK_FREQ=1000, UART_BPS=100, TIMEOUT_BYTES=2, so TIMEOUT_CYC=200): AA 10 then idle -> err_valid with err_code=10 exactly 200 cycles after the 0x10 strobe, busy drops. A byte landing on cycle 199 instead must be accepted with no error.
- Leading garbage: 55 00 AA 01 00 FF FE -> exactly one write, addr=0x01, data=0x00FF. The first two bytes produce no error.
- Reset mid-packet: AA 10, pulse sys_rst for 1 cycle, then 12 34 36 -> no write, no error, busy=0. Then a full AA 10 12 34 36 writes correctly.
- Back-to-back with embedded sync value: AA AA AA AA AA immediately followed by AA 01 02 03 00 -> write addr=AA data=AAAA (checksum AA^AA^AA=AA), then write addr=01 data=0203.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parser FSM states, error codes, sync marker
// and the baud/timeout sizing formulas used across the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CSUM
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

  // Clock cycles per bit minus one; the rx/tx bit counters wrap here.
  function automatic int baud_cnt_max(input int clk_freq,
                                      input int bps);
    return (clk_freq / bps) - 1;
  endfunction

  // A character is 10 bit times (start + 8 data + stop).
  function automatic int timeout_cycles(input int nbytes,
                                        input int clk_freq,
                                        input int bps);
    return nbytes * 10 * (baud_cnt_max(clk_freq, bps) + 1);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles and flags the terminal count.
// Ports: clk_i, rst_i (sync, high), clear_i, enable_i, expire_o.
module uart_gap_timer #(
  parameter int CYC = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A clear (new byte) on the terminal cycle suppresses the expiry.
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/ADDR/DHI/DLO/CSUM packets from the UART rx byte stream and
// issues register writes or error strobes.
// Ports: sys_clk, sys_rst (sync, high), in_data/in_valid byte stream,
// reg_wr_en/reg_addr/reg_wr_data write port, err_valid/err_code, busy.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         UART_BPS      = 9600,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int TIMEOUT_CYC =
    timeout_cycles(TIMEOUT_BYTES, CLK_FREQ, UART_BPS);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  raddr_q, raddr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        gap_expire;
  logic        gap_clear;

  assign busy      = (state_q != ST_IDLE);
  assign gap_clear = (state_q == ST_IDLE) || in_valid;

  uart_gap_timer #(
    .CYC(TIMEOUT_CYC)
  ) u_gap (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .clear_i (gap_clear),
    .enable_i(busy),
    .expire_o(gap_expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    csum_d  = csum_q;
    wr_en_d = 1'b0;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (in_valid) begin
          addr_d  = in_data;
          csum_d  = in_data;
          state_d = ST_DHI;
        end
      end
      ST_DHI: begin
        if (in_valid) begin
          dhi_d   = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = ST_DLO;
        end
      end
      ST_DLO: begin
        if (in_valid) begin
          dlo_d   = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (in_valid) begin
          state_d = ST_IDLE;
          if (in_data == csum_q) begin
            wr_en_d = 1'b1;
            raddr_d = addr_q;
            rdata_d = {dhi_q, dlo_q};
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Expiry only fires with no byte present, so it never
    // collides with the checksum decision above.
    if (gap_expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      csum_q  <= '0;
      wr_en_q <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      csum_q  <= csum_d;
      wr_en_q <= wr_en_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_addr    = raddr_q;
  assign reg_wr_data = rdata_q;
  assign err_valid   = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: packet-level model plus
// directed scenarios with literal expectations.
module tb_uart_cmd_parser;

  localparam int TO_CYC = 200;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .CLK_FREQ     (1000),
    .UART_BPS     (100),
    .TIMEOUT_BYTES(2),
    .SYNC_BYTE    (8'hAA)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .busy       (busy)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Packet-level model: collect bytes after a sync, judge at five,
  // count idle cycles while a packet is open.
  logic [7:0]  pkt[$];
  int          gap = 0;
  logic        m_wr = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_busy = 1'b0;

  always @(posedge clk) begin
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (sys_rst) begin
      pkt.delete();
      gap    = 0;
      m_addr = 8'h00;
      m_data = 16'h0000;
      m_code = 2'd0;
    end else if (in_valid) begin
      gap = 0;
      if (pkt.size() == 0) begin
        if (in_data == 8'hAA) pkt.push_back(in_data);
      end else begin
        pkt.push_back(in_data);
        if (pkt.size() == 5) begin
          if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
            m_wr   = 1'b1;
            m_addr = pkt[1];
            m_data = {pkt[2], pkt[3]};
          end else begin
            m_err  = 1'b1;
            m_code = 2'd1;
          end
          pkt.delete();
        end
      end
    end else if (pkt.size() != 0) begin
      gap++;
      if (gap == TO_CYC) begin
        m_err  = 1'b1;
        m_code = 2'd2;
        pkt.delete();
        gap = 0;
      end
    end
    m_busy = (pkt.size() != 0);
  end

  always @(negedge clk) begin
    chk("wr_en", 32'(reg_wr_en), 32'(m_wr));
    chk("err_valid", 32'(err_valid), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("reg_addr", 32'(reg_addr), 32'(m_addr));
    chk("reg_wr_data", 32'(reg_wr_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("exclusive", 32'(reg_wr_en & err_valid), 32'd0);
    if (reg_wr_en) wr_cnt++;
    if (err_valid) err_cnt++;
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pkt5(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      input logic [7:0] e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int e0;
    sys_rst = 1'b1;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    sys_rst = 1'b0;
    idle(2);

    // Nominal packet: write one cycle after the checksum byte.
    w0 = wr_cnt;
    pkt5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
    chk("nom_wr_pulse", 32'(reg_wr_en), 32'd1);
    chk("nom_addr", 32'(reg_addr), 32'h10);
    chk("nom_data", 32'(reg_wr_data), 32'h1234);
    idle(3);
    chk("nom_one_write", 32'(wr_cnt - w0), 32'd1);

    // Bad checksum: error strobe, register port unchanged.
    w0 = wr_cnt;
    pkt5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h37);
    chk("bad_err", 32'(err_valid), 32'd1);
    chk("bad_code", 32'(err_code), 32'd1);
    chk("bad_addr_hold", 32'(reg_addr), 32'h10);
    idle(3);
    chk("bad_no_write", 32'(wr_cnt - w0), 32'd0);

    // Timeout: error exactly 200 cycles after the 0x10 byte.
    send(8'hAA);
    send(8'h10);
    idle(TO_CYC - 1);
    chk("to_early_err", 32'(err_valid), 32'd0);
    chk("to_early_busy", 32'(busy), 32'd1);
    idle(1);
    chk("to_err", 32'(err_valid), 32'd1);
    chk("to_code", 32'(err_code), 32'd2);
    chk("to_busy", 32'(busy), 32'd0);
    idle(3);

    // Byte on the terminal count wins over the timeout.
    w0 = wr_cnt;
    e0 = err_cnt;
    send(8'hAA);
    send(8'h10);
    idle(TO_CYC - 1);
    send(8'h12);
    send(8'h34);
    send(8'h36);
    idle(2);
    chk("edge_write", 32'(wr_cnt - w0), 32'd1);
    chk("edge_no_err", 32'(err_cnt - e0), 32'd0);

    // Leading garbage is dropped silently.
    w0 = wr_cnt;
    e0 = err_cnt;
    send(8'h55);
    send(8'h00);
    pkt5(8'hAA, 8'h01, 8'h00, 8'hFF, 8'hFE);
    idle(2);
    chk("garb_write", 32'(wr_cnt - w0), 32'd1);
    chk("garb_no_err", 32'(err_cnt - e0), 32'd0);
    chk("garb_addr", 32'(reg_addr), 32'h01);
    chk("garb_data", 32'(reg_wr_data), 32'h00FF);

    // Reset mid-packet discards it; reset also clears held outputs.
    send(8'hAA);
    send(8'h10);
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    w0 = wr_cnt;
    e0 = err_cnt;
    send(8'h12);
    send(8'h34);
    send(8'h36);
    idle(2);
    chk("rstp_busy", 32'(busy), 32'd0);
    chk("rstp_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rstp_no_err", 32'(err_cnt - e0), 32'd0);
    chk("rstp_addr_clr", 32'(reg_addr), 32'd0);
    pkt5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
    idle(2);
    chk("rstp_write", 32'(wr_cnt - w0), 32'd1);
    chk("rstp_data", 32'(reg_wr_data), 32'h1234);

    // Back-to-back packets with sync value used as data.
    w0 = wr_cnt;
    pkt5(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    chk("b2b_addr1", 32'(reg_addr), 32'hAA);
    chk("b2b_data1", 32'(reg_wr_data), 32'hAAAA);
    pkt5(8'hAA, 8'h01, 8'h02, 8'h03, 8'h00);
    chk("b2b_addr2", 32'(reg_addr), 32'h01);
    chk("b2b_data2", 32'(reg_wr_data), 32'h0203);
    idle(3);
    chk("b2b_writes", 32'(wr_cnt - w0), 32'd2);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
